// File: rtl/forest_pkg.sv
// Shared types and constants for the random-forest vote scheduler: FSM state
// encoding, default sizing and the weather feature bundle.
package forest_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_NEXT = 3'd2,
      ST_SCAN = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam int NUM_TREES_D   = 9;
   localparam int NUM_CLASSES_D = 5;
   localparam int FEAT_W_D      = 5;

   typedef struct packed {
      logic [FEAT_W_D-1:0] temp_max;
      logic [FEAT_W_D-1:0] temp_min;
      logic [FEAT_W_D-1:0] precipitation;
      logic [FEAT_W_D-1:0] wind;
   } weather_t;

   // Index width that stays legal even for a single-entry range.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Counter width that can hold 0..n inclusive, so a tally never wraps.
   function automatic int tally_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/vote_tally.sv
// Per-class vote counters plus a one-class-per-cycle argmax scan; ties keep
// the lower class index because only a strictly larger count replaces best.
module vote_tally
   import forest_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_D,
   parameter int IDX_W       = idx_w(NUM_CLASSES_D),
   parameter int CNT_W       = tally_w(NUM_TREES_D)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   input  logic [IDX_W-1:0] inc_cls,
   input  logic             scan_init,
   input  logic             scan_en,
   output logic             scan_last,
   output logic [IDX_W-1:0] best_nxt
);

   logic [CNT_W-1:0] tally [NUM_CLASSES];
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] best;
   logic [CNT_W-1:0] best_cnt;
   logic             take;

   assign take      = tally[idx] > best_cnt;
   assign best_nxt  = take ? idx : best;
   assign scan_last = (idx == IDX_W'(NUM_CLASSES - 1));

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CLASSES; c++) begin
            tally[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CLASSES; c++) begin
            if (clear) begin
               tally[c] <= '0;
            end else if (inc && (inc_cls == IDX_W'(c))) begin
               tally[c] <= tally[c] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         idx      <= '0;
         best     <= '0;
         best_cnt <= '0;
      end else if (scan_init) begin
         idx      <= '0;
         best     <= '0;
         best_cnt <= '0;
      end else if (scan_en) begin
         best <= best_nxt;
         if (take) begin
            best_cnt <= tally[idx];
         end
         if (!scan_last) begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/forest_vote_scheduler.sv
// Time-multiplexes one shared tree engine over all forest trees and reports
// the majority class. Optional engine watchdog: FOREST_ENGINE_TIMEOUT_EN.
//
// Handshakes: in_valid/in_ready and out_valid/out_ready transfer when both are
// high at a rising edge; eng_req is held until a single-cycle eng_ack, and
// eng_ack seen in any other state is dropped.
module forest_vote_scheduler
   import forest_pkg::*;
#(
   parameter int NUM_TREES   = NUM_TREES_D,
   parameter int NUM_CLASSES = NUM_CLASSES_D,
   parameter int FEAT_W      = FEAT_W_D,
   parameter int CLASS_W     = 5,
   parameter int RES_W       = 4
`ifdef FOREST_ENGINE_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 64
`endif
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [FEAT_W-1:0]  in_temp_max,
   input  logic [FEAT_W-1:0]  in_temp_min,
   input  logic [FEAT_W-1:0]  in_precipitation,
   input  logic [FEAT_W-1:0]  in_wind,
   output logic               eng_req,
   output logic [3:0]         eng_tree,
   output logic [FEAT_W-1:0]  eng_temp_max,
   output logic [FEAT_W-1:0]  eng_temp_min,
   output logic [FEAT_W-1:0]  eng_precipitation,
   output logic [FEAT_W-1:0]  eng_wind,
   input  logic               eng_ack,
   input  logic [CLASS_W-1:0] eng_class,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [RES_W-1:0]   result,
   output logic               bad_class,
   output logic               busy,
`ifdef FOREST_ENGINE_TIMEOUT_EN
   output logic               eng_timeout,
`endif
   output logic [2:0]         fsm_state
);

   localparam int IDX_W = idx_w(NUM_CLASSES);
   localparam int CNT_W = tally_w(NUM_TREES);

   localparam logic [2:0] S_IDLE = ST_IDLE;
   localparam logic [2:0] S_REQ  = ST_REQ;
   localparam logic [2:0] S_NEXT = ST_NEXT;
   localparam logic [2:0] S_SCAN = ST_SCAN;
   localparam logic [2:0] S_DONE = ST_DONE;

   logic [2:0]       state;
   logic [3:0]       tree;
   logic             last_tree;
   logic             class_ok;
   logic             timeout_hit;
   logic             tally_clear;
   logic             tally_inc;
   logic             scan_init;
   logic             scan_en;
   logic             scan_last;
   logic [IDX_W-1:0] best_nxt;

   assign fsm_state = state;
   assign in_ready  = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign eng_req   = (state == S_REQ);
   assign eng_tree  = tree;
   assign last_tree = (tree == 4'(NUM_TREES - 1));
   assign class_ok  = (32'(eng_class) < NUM_CLASSES);

   assign tally_clear = (state == S_IDLE) && in_valid;
   assign tally_inc   = (state == S_REQ) && eng_ack && class_ok;
   assign scan_init   = (state == S_NEXT) && last_tree;
   assign scan_en     = (state == S_SCAN);

`ifdef FOREST_ENGINE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt;

   // The REQ cycle that sees the count reach TIMEOUT_CYC-1 is the last one.
   assign timeout_hit = (state == S_REQ) && !eng_ack &&
                        (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clock) begin
      if (!reset) begin
         tmo_cnt     <= '0;
         eng_timeout <= 1'b0;
      end else begin
         if (state == S_REQ) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end else begin
            tmo_cnt <= '0;
         end
         if (timeout_hit) begin
            eng_timeout <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state             <= S_IDLE;
         tree              <= '0;
         eng_temp_max      <= '0;
         eng_temp_min      <= '0;
         eng_precipitation <= '0;
         eng_wind          <= '0;
         out_valid         <= 1'b0;
         result            <= '0;
         bad_class         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  eng_temp_max      <= in_temp_max;
                  eng_temp_min      <= in_temp_min;
                  eng_precipitation <= in_precipitation;
                  eng_wind          <= in_wind;
                  tree              <= '0;
                  state             <= S_REQ;
               end
            end
            S_REQ: begin
               if (eng_ack) begin
                  if (!class_ok) begin
                     bad_class <= 1'b1;
                  end
                  state <= S_NEXT;
               end else if (timeout_hit) begin
                  state <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (last_tree) begin
                  state <= S_SCAN;
               end else begin
                  tree  <= tree + 1'b1;
                  state <= S_REQ;
               end
            end
            S_SCAN: begin
               // best_nxt already folds in the final class's count.
               if (scan_last) begin
                  result    <= RES_W'(best_nxt);
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   vote_tally #(
      .NUM_CLASSES (NUM_CLASSES),
      .IDX_W       (IDX_W),
      .CNT_W       (CNT_W)
   ) u_vote_tally (
      .clock     (clock),
      .reset     (reset),
      .clear     (tally_clear),
      .inc       (tally_inc),
      .inc_cls   (eng_class[IDX_W-1:0]),
      .scan_init (scan_init),
      .scan_en   (scan_en),
      .scan_last (scan_last),
      .best_nxt  (best_nxt)
   );

endmodule

// File: tb/tb_forest_vote_scheduler.sv
// Directed bench for forest_vote_scheduler with a behavioural engine that
// answers each tree from a vote table after a programmable delay.
module tb_forest_vote_scheduler;
   import forest_pkg::*;

   logic       clock;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_temp_max, in_temp_min, in_precipitation, in_wind;
   logic       eng_req;
   logic [3:0] eng_tree;
   logic [4:0] eng_temp_max, eng_temp_min, eng_precipitation, eng_wind;
   logic       eng_ack;
   logic [4:0] eng_class;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] result;
   logic       bad_class;
   logic       busy;
   logic [2:0] fsm_state;
`ifdef FOREST_ENGINE_TIMEOUT_EN
   logic       eng_timeout;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // engine model controls
   logic [4:0] votes [9];
   int         max_delay   = 0;
   int         no_ack_tree = -1;
   bit         chk_stable  = 0;
   int         inject_cnt  = 0;
   int         inject_done = 0;
   bit         req_seen    = 0;
   logic [3:0] held_tree   = '0;
   int         wait_cnt    = 0;
   int         cur_delay   = 0;

   forest_vote_scheduler dut (
      .clock             (clock),
      .reset             (reset),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_temp_max       (in_temp_max),
      .in_temp_min       (in_temp_min),
      .in_precipitation  (in_precipitation),
      .in_wind           (in_wind),
      .eng_req           (eng_req),
      .eng_tree          (eng_tree),
      .eng_temp_max      (eng_temp_max),
      .eng_temp_min      (eng_temp_min),
      .eng_precipitation (eng_precipitation),
      .eng_wind          (eng_wind),
      .eng_ack           (eng_ack),
      .eng_class         (eng_class),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .result            (result),
      .bad_class         (bad_class),
      .busy              (busy),
`ifdef FOREST_ENGINE_TIMEOUT_EN
      .eng_timeout       (eng_timeout),
`endif
      .fsm_state         (fsm_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Engine: acts on the falling edge so the scheduler samples ack at the next rise.
   always @(negedge clock) begin
      if (!reset) begin
         req_seen = 0;
      end
      if (eng_ack) begin
         eng_ack = 1'b0;
      end else if (inject_cnt != inject_done) begin
         eng_ack   = 1'b1;
         eng_class = 5'd2;
         inject_done++;
      end else if (eng_req && reset) begin
         if (!req_seen) begin
            req_seen  = 1;
            held_tree = eng_tree;
            wait_cnt  = 0;
            cur_delay = (max_delay == 0) ? 0 : int'($urandom_range(0, max_delay));
         end else if (chk_stable) begin
            check_eq("eng_tree_stable", 32'(eng_tree), 32'(held_tree));
            check_eq("in_ready_busy", 32'(in_ready), 0);
         end
         if (int'(eng_tree) != no_ack_tree && wait_cnt >= cur_delay) begin
            eng_ack   = 1'b1;
            eng_class = votes[eng_tree];
            req_seen  = 0;
         end else begin
            wait_cnt++;
         end
      end
   end

   task automatic start_sample(input weather_t s);
      @(negedge clock);
      in_temp_max      = s.temp_max;
      in_temp_min      = s.temp_min;
      in_precipitation = s.precipitation;
      in_wind          = s.wind;
      in_valid         = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   // lat counts cycles from the accept cycle to the first cycle with out_valid.
   task automatic wait_out(output int lat, output bit ok);
      lat = 1;
      while (lat < 3000 && !out_valid) begin
         @(posedge clock);
         #1;
         lat++;
      end
      ok = out_valid;
      check_eq("out_valid_seen", 32'(ok), 1);
   endtask

   task automatic release_out();
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      check_eq("out_valid_drop", 32'(out_valid), 0);
      check_eq("back_to_idle", 32'(in_ready), 1);
   endtask

   initial begin
      weather_t s;
      int       lat;
      bit       ok;
      int       guard;

      reset = 1'b0;  in_valid = 1'b0;  out_ready = 1'b0;
      eng_ack = 1'b0;  eng_class = '0;
      in_temp_max = '0; in_temp_min = '0; in_precipitation = '0; in_wind = '0;
      for (int i = 0; i < 9; i++) votes[i] = 5'd2;

      // reset state
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_state", 32'(fsm_state), 0);
      check_eq("rst_eng_req", 32'(eng_req), 0);
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_result", 32'(result), 0);
      check_eq("rst_bad_class", 32'(bad_class), 0);
      check_eq("rst_eng_tree", 32'(eng_tree), 0);
      check_eq("rst_feat", 32'({eng_temp_max, eng_temp_min, eng_precipitation, eng_wind}), 0);
      check_eq("rst_in_ready", 32'(in_ready), 1);
      check_eq("rst_busy", 32'(busy), 0);
`ifdef FOREST_ENGINE_TIMEOUT_EN
      check_eq("rst_eng_timeout", 32'(eng_timeout), 0);
`endif
      @(negedge clock);
      reset = 1'b1;

      // 1: all trees vote 2, zero-delay engine
      s = '{temp_max: 5'd21, temp_min: 5'd9, precipitation: 5'd3, wind: 5'd14};
      start_sample(s);
      check_eq("t1_busy", 32'(busy), 1);
      wait_out(lat, ok);
      check_eq("t1_latency", 32'(lat), 24);
      check_eq("t1_result", 32'(result), 2);
      check_eq("t1_bad_class", 32'(bad_class), 0);
      check_eq("t1_features", 32'({eng_temp_max, eng_temp_min, eng_precipitation, eng_wind}),
               32'({5'd21, 5'd9, 5'd3, 5'd14}));
      release_out();
      check_eq("t1_result_kept", 32'(result), 2);

      // 2: tie between classes 1 and 3 (four votes each)
      votes = '{5'd1, 5'd1, 5'd3, 5'd3, 5'd3, 5'd1, 5'd0, 5'd3, 5'd1};
      start_sample(s);
      wait_out(lat, ok);
      check_eq("t2_tie_result", 32'(result), 1);
      release_out();

      // 3: one out-of-range vote
      votes = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0};
      start_sample(s);
      wait_out(lat, ok);
      check_eq("t3_bad_class", 32'(bad_class), 1);
      check_eq("t3_result", 32'(result), 0);
      release_out();

      // 4: random ack delays, sink stalls for ten cycles
      votes = '{5'd4, 5'd4, 5'd2, 5'd2, 5'd2, 5'd0, 5'd1, 5'd4, 5'd2};
      max_delay  = 5;
      chk_stable = 1;
      start_sample(s);
      wait_out(lat, ok);
      chk_stable = 0;
      max_delay  = 0;
      check_eq("t4_result", 32'(result), 2);
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         check_eq("t4_hold_valid", 32'(out_valid), 1);
         check_eq("t4_hold_result", 32'(result), 2);
         check_eq("t4_hold_in_ready", 32'(in_ready), 0);
      end
      release_out();

      // 5: every tree returns an invalid code
      for (int i = 0; i < 9; i++) votes[i] = 5'd9;
      start_sample(s);
      wait_out(lat, ok);
      check_eq("t5_all_invalid_result", 32'(result), 0);
      check_eq("t5_bad_class_sticky", 32'(bad_class), 1);
      release_out();

      // 6: reset in the middle of tree 5, then a stray ack
      for (int i = 0; i < 9; i++) votes[i] = 5'd1;
      no_ack_tree = 5;
      start_sample(s);
      guard = 0;
      while (guard < 200 && !(eng_req && eng_tree == 4'd5)) begin
         @(posedge clock);
         #1;
         guard++;
      end
      check_eq("t6_reached_tree5", 32'(eng_req && eng_tree == 4'd5), 1);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check_eq("t6_rst_req", 32'(eng_req), 0);
      check_eq("t6_rst_tree", 32'(eng_tree), 0);
      check_eq("t6_rst_busy", 32'(busy), 0);
      check_eq("t6_rst_bad_class", 32'(bad_class), 0);
      check_eq("t6_rst_feat", 32'(eng_temp_max), 0);
      @(negedge clock);
      reset = 1'b1;
      no_ack_tree = -1;
      inject_cnt++;
      repeat (3) @(posedge clock);
      #1;
      check_eq("t6_stray_ack_state", 32'(fsm_state), 0);
      check_eq("t6_stray_ack_req", 32'(eng_req), 0);
      check_eq("t6_stray_ack_bad", 32'(bad_class), 0);
      for (int i = 0; i < 9; i++) votes[i] = 5'd4;
      start_sample(s);
      wait_out(lat, ok);
      check_eq("t6_result", 32'(result), 4);
      check_eq("t6_latency", 32'(lat), 24);
      release_out();

`ifdef FOREST_ENGINE_TIMEOUT_EN
      // 7: tree 0 never answers, the rest vote 3
      for (int i = 0; i < 9; i++) votes[i] = 5'd3;
      no_ack_tree = 0;
      start_sample(s);
      repeat (63) @(posedge clock);
      #1;
      check_eq("t7_no_timeout_yet", 32'(eng_timeout), 0);
      @(posedge clock);
      #1;
      check_eq("t7_timeout", 32'(eng_timeout), 1);
      wait_out(lat, ok);
      check_eq("t7_result", 32'(result), 3);
      no_ack_tree = -1;
      release_out();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/forest_vote_scheduler.md
Name: forest_vote_scheduler

Overview:
- Time-multiplexes one shared decision-tree evaluation engine across all trees of the weather random forest, in place of nine parallel tree instances.
- Latches one weather sample and issues it to the engine once per tree index, with a req/ack handshake.
- Tallies per-class votes, then scans the tallies to produce the majority class.
- Sits between the sample source (fixed inputs or host) and the LED/result sink.

Parameters:
- NUM_TREES, 9, number of trees evaluated per sample (1..15)
- NUM_CLASSES, 5, number of valid class codes (0..NUM_CLASSES-1, max 16)
- FEAT_W, 5, width of each weather feature
- CLASS_W, 5, width of engine class code
- RES_W, 4, width of result output
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with macro)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  sample offered
- in_ready  out  1  scheduler can accept a sample (high only in IDLE)
- in_temp_max / in_temp_min / in_precipitation / in_wind  in  FEAT_W each  sample features
- eng_req  out  1  engine request, held until ack
- eng_tree  out  4  tree index for current request
- eng_temp_max / eng_temp_min / eng_precipitation / eng_wind  out  FEAT_W each  latched features, stable for the whole sample
- eng_ack  in  1  one-cycle pulse: eng_class valid
- eng_class  in  CLASS_W  class voted by tree eng_tree
- out_valid  out  1  result available
- out_ready  in  1  sink accepts result
- result  out  RES_W  majority class
- bad_class  out  1  sticky: engine returned code >= NUM_CLASSES
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE.
  - Outputs cleared: eng_req, out_valid, result, bad_class; eng_tree=0; feature regs=0; all tallies=0.
  - Reset mid-operation aborts the sample; a late eng_ack is ignored.
- States:
  - IDLE: in_ready=1. On in_valid: latch features, clear tallies, tree=0, go to REQ.
  - REQ: eng_req=1 with eng_tree=tree. Stays in REQ until eng_ack.
    - On ack: if eng_class<NUM_CLASSES, increment tally[eng_class]; otherwise set bad_class and count nothing.
    - Same edge: eng_req drops for one cycle (go to NEXT).
    - ack arriving in the first REQ cycle is legal.
  - NEXT: if tree==NUM_TREES-1, go to SCAN with idx=0, best=0, bestcnt=0. Else tree++ and go to REQ.
  - SCAN: one class per cycle, NUM_CLASSES cycles.
    - If tally[idx]>bestcnt, then best=idx and bestcnt=tally[idx].
    - Strict greater-than means ties resolve to the lowest class index.
    - After the last idx: result=best, out_valid=1, go to DONE.
  - DONE: hold result and out_valid until out_ready. On out_valid&&out_ready: out_valid=0, go to IDLE. result retains its value.
- Tallies are $clog2(NUM_TREES+1) bits wide and cannot overflow.
- All-invalid sample (every tree returned an out-of-range code): result=0.
- eng_ack outside REQ is ignored.
- in_valid outside IDLE is not accepted (in_ready=0).
- Latency with an engine that acks in the first REQ cycle: 1 (IDLE) + 2·NUM_TREES + NUM_CLASSES cycles from accept to out_valid. With defaults that is 24.
- bad_class clears only on reset.

Optional Feature:
- Macro: FOREST_ENGINE_TIMEOUT_EN.
- With the macro:
  - A counter runs while in REQ and reloads on every entry to REQ.
  - If it reaches TIMEOUT_CYC without an ack: the tree counts no vote, a sticky output eng_timeout (1 bit, reset 0) is set, and the FSM proceeds to NEXT.
- Without the macro: REQ waits indefinitely and the eng_timeout port does not exist.

Decomposition:
- Shared package forest_pkg holds:
  - state enum (IDLE, REQ, NEXT, SCAN, DONE);
  - default constants NUM_TREES_D=9, NUM_CLASSES_D=5, FEAT_W_D=5;
  - a typedef for the weather feature bundle.
- One natural sub-module, vote_tally:
  - per-class counters with clear/increment;
  - sequential argmax scan with best/bestcnt registers.
- The scheduler FSM stays in the top module.

Test Plan:
- Single sample, engine always acks class 2 in the first REQ cycle. Required: out_valid after exactly 24 cycles, result=2, bad_class=0.
- Engine returns votes 1,1,3,3,3,1,0,3,1 (classes 1 and 3 tied at 4 each). Required: result=1 (lowest-index tie-break).
- Engine returns class 7 for tree 4, class 0 for all others. Required: bad_class=1, result=0.
- Engine ack delayed 0–5 random cycles, out_ready held low for 10 cycles. Required: eng_req and eng_tree stable until ack; result and out_valid held; in_ready=0 throughout.
- Assert reset=0 during tree 5 REQ, then issue an ack. Required: outputs reset next edge; ack ignored; new sample with all-4 votes gives result=4.
- FOREST_ENGINE_TIMEOUT_EN defined, engine never acks tree 0, others ack 3. Required: eng_timeout=1 after 64 cycles, result=3.
